video_priority_mixer: RTL and testbench
=======================================

Name: video_priority_mixer

Overview:
- Pixel-rate stage directly downstream of the tile generation subsystem.
- Merges the tile path's final palette index (DOT) and priority (PR) with the sprite path's colour/priority, per pixel, and emits a palette address to the colour PROM/DAC stage.
- Generates the active-display window and blanking from nHSYNC/nVSYNC.
- Holds a CPU-written back colour shown outside the window.
- Realigns sync outputs with the 2-cycle pixel pipeline.

Parameters:
- SPR_TRANS, 8'hFF: sprite colour index treated as transparent.
- HSTART, 9'd24: first active pixel count after nHSYNC falling edge.
- HEND, 9'd312: first inactive pixel count (exclusive).
- VSTART, 9'd16: first active line after nVSYNC falling edge.
- VEND, 9'd240: first inactive line (exclusive).

Ports:
- CLK_6M  in  1  pixel clock; all logic on rising edge.
- nRST  in  1  synchronous active-low reset.
- DOT  in  8  tile palette index from tilegen.
- PR  in  3  tile priority from tilegen.
- SCOL  in  8  sprite palette index.
- SPRI  in  3  sprite priority.
- nHSYNC  in  1  horizontal sync, active low.
- nVSYNC  in  1  vertical sync, active low.
- nBGWE  in  1  back-colour write strobe, active low, sampled per clock.
- MD  in  8  back-colour data.
- PAL_A  out  9  palette address; bit 8 = 1 for sprite source, 0 for tile/back colour; bits 7:0 = index.
- nBLANK  out  1  low outside the active window.
- nHSYNC_O  out  1  nHSYNC delayed 2 cycles.
- nVSYNC_O  out  1  nVSYNC delayed 2 cycles.

Behaviour:
- Reset (nRST low at clock edge): PAL_A=0, nBLANK=0, nHSYNC_O=1, nVSYNC_O=1, hcnt=0, vcnt=0, back-colour register=0. Edge-detect history registers are set to 1, so no edge is detected on the first cycle after reset.
- Reset applied mid-line discards the pipeline contents. Outputs hold their reset values until 2 valid cycles have passed after nRST goes high.
- Edge detect: a falling edge occurs in a cycle where the registered previous value is 1 and the current value is 0.
- hcnt (9 bit):
  - cleared to 0 on the clock after an nHSYNC falling edge;
  - otherwise +1 per clock;
  - saturates at 9'h1FF (no wrap).
- vcnt (9 bit):
  - +1 on each nHSYNC falling edge;
  - cleared on an nVSYNC falling edge;
  - if both edges occur in the same cycle, the clear wins;
  - saturates at 9'h1FF.
- active = (HSTART <= hcnt < HEND) && (VSTART <= vcnt < VEND), evaluated on current counter values.
- Back colour: while nBGWE=0 at a clock edge, load MD. The new value is used for pixels entering stage 1 on the following cycle.
- Stage 1 (registered): capture DOT, PR, SCOL, SPRI, active, nHSYNC, nVSYNC.
- Stage 2 (registered outputs), source selection:
  - if !active: PAL_A={0,backcolour};
  - else if SCOL!=SPR_TRANS and SPRI>=PR: PAL_A={1,SCOL} (equal priority goes to the sprite);
  - else PAL_A={0,DOT}.
- nBLANK = stage-1 active.
- Latency: exactly 2 CLK_6M cycles from input to PAL_A, nBLANK and the sync outputs; all four outputs stay aligned.
- Pipeline has no stall and no enable; it runs every clock.

Optional Feature:
- Macro: VIDEO_MIXER_LAYER_MASK_EN.
- When defined:
  - adds input LMASK[1:0], registered in stage 1.
  - LMASK[0]=1 forces the sprite transparent.
  - LMASK[1]=1 replaces the tile index with the back colour while still keeping PR for comparison.
- When undefined: no LMASK port, and behaviour is exactly as above.

Decomposition:
- Shared package video_mixer_pkg holds:
  - the PAL_A source-bit position;
  - widths (index 8, priority 3, counter 9);
  - default window constants;
  - a pal_addr_t typedef.
- One natural sub-module: video_window_counter (sync edge detect, hcnt/vcnt, active flag).
- Priority selection and the pipeline stay in the top module.

Test Plan:
- Reset: hold nRST low for 3 clocks with random inputs -> PAL_A=0, nBLANK=0, both sync outputs=1 throughout; first input sampled after release appears 2 cycles later.
- Window: nVSYNC falling edge, then 20 nHSYNC falling edges, then sweep hcnt -> nBLANK=1 only for hcnt 24..311 on lines 16..239, delayed 2 cycles. Outside the window PAL_A equals the back colour (after writing MD=8'h5A: PAL_A=9'h05A).
- Priority inside the window:
  - DOT=8'h12, PR=3, SCOL=8'h34, SPRI=3 -> PAL_A=9'h134;
  - SPRI=2 -> 9'h012;
  - SCOL=8'hFF, SPRI=7 -> 9'h012.
- Simultaneous events:
  - nHSYNC and nVSYNC falling in the same cycle -> vcnt=0 and hcnt=0 next cycle;
  - nBGWE write while outside the window -> PAL_A changes 2 cycles after the following pixel enters.
- Saturation: hold nHSYNC high for 600 clocks -> hcnt stops at 511, no wrap; nBLANK stays 0.
- VIDEO_MIXER_LAYER_MASK_EN build, inside the window with SPRI>=PR:
  - LMASK=2'b01, SCOL=8'h34, DOT=8'h12 -> PAL_A=9'h012;
  - LMASK=2'b10, SCOL=8'hFF, back colour 8'h5A -> PAL_A=9'h05A.

Source files
------------

// File: rtl/video_mixer_pkg.sv
// Shared constants and types for the video priority mixer.
// Optional layer-mask feature is enabled with the macro VIDEO_MIXER_LAYER_MASK_EN.
package video_mixer_pkg;

    localparam int IDX_W       = 8;   // palette index width
    localparam int PRI_W       = 3;   // priority width
    localparam int CNT_W       = 9;   // pixel/line counter width
    localparam int PAL_SRC_BIT = 8;   // PAL_A bit that flags a sprite source

    localparam logic [IDX_W-1:0] DEF_SPR_TRANS = 8'hFF;
    localparam logic [CNT_W-1:0] DEF_HSTART    = 9'd24;
    localparam logic [CNT_W-1:0] DEF_HEND      = 9'd312;
    localparam logic [CNT_W-1:0] DEF_VSTART    = 9'd16;
    localparam logic [CNT_W-1:0] DEF_VEND      = 9'd240;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 9'd1;

    typedef logic [PAL_SRC_BIT:0] pal_addr_t;

    // Build a palette address from a source flag and an index.
    function automatic pal_addr_t make_pal(input logic spr, input logic [IDX_W-1:0] idx);
        return {spr, idx};
    endfunction

endpackage

// File: rtl/video_priority_mixer_if.sv
// Pixel bus between tilegen/sprite/sync sources, the mixer and the colour PROM stage.
// LMASK only exists when VIDEO_MIXER_LAYER_MASK_EN is defined.
// Signalling: no handshake; every signal is valid on every CLK_6M rising edge,
// the mixer never stalls and its outputs are registered.
interface video_priority_mixer_if;
    import video_mixer_pkg::*;

    logic [IDX_W-1:0] DOT;
    logic [PRI_W-1:0] PR;
    logic [IDX_W-1:0] SCOL;
    logic [PRI_W-1:0] SPRI;
    logic             nHSYNC;
    logic             nVSYNC;
    logic             nBGWE;
    logic [IDX_W-1:0] MD;
`ifdef VIDEO_MIXER_LAYER_MASK_EN
    logic [1:0]       LMASK;
`endif
    pal_addr_t        PAL_A;
    logic             nBLANK;
    logic             nHSYNC_O;
    logic             nVSYNC_O;

    // Mixer side
    modport slave (
        input  DOT, PR, SCOL, SPRI, nHSYNC, nVSYNC, nBGWE, MD,
`ifdef VIDEO_MIXER_LAYER_MASK_EN
        input  LMASK,
`endif
        output PAL_A, nBLANK, nHSYNC_O, nVSYNC_O
    );

    // Source / sink side
    modport master (
        output DOT, PR, SCOL, SPRI, nHSYNC, nVSYNC, nBGWE, MD,
`ifdef VIDEO_MIXER_LAYER_MASK_EN
        output LMASK,
`endif
        input  PAL_A, nBLANK, nHSYNC_O, nVSYNC_O
    );

endinterface

// File: rtl/video_window_counter.sv
// Sync falling-edge detection, pixel/line counters and active-window flag.
// Counters saturate rather than wrap so a missing sync never re-opens the window.
module video_window_counter
    import video_mixer_pkg::*;
#(
    parameter logic [CNT_W-1:0] HSTART = DEF_HSTART,
    parameter logic [CNT_W-1:0] HEND   = DEF_HEND,
    parameter logic [CNT_W-1:0] VSTART = DEF_VSTART,
    parameter logic [CNT_W-1:0] VEND   = DEF_VEND
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_hsync_n,
    input  logic i_vsync_n,
    output logic o_active
);

    logic             r_hs_prev;
    logic             r_vs_prev;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             w_hfall;
    logic             w_vfall;

    assign w_hfall = r_hs_prev & ~i_hsync_n;
    assign w_vfall = r_vs_prev & ~i_vsync_n;

    // Sync history (reset high so no edge is seen right after reset) and counters;
    // a vsync edge clears vcnt even when an hsync edge lands in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hs_prev <= 1'b1;
            r_vs_prev <= 1'b1;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
        end else begin
            r_hs_prev <= i_hsync_n;
            r_vs_prev <= i_vsync_n;
            if (w_hfall)
                r_hcnt <= '0;
            else if (r_hcnt != CNT_MAX)
                r_hcnt <= r_hcnt + CNT_ONE;
            if (w_vfall)
                r_vcnt <= '0;
            else if (w_hfall && (r_vcnt != CNT_MAX))
                r_vcnt <= r_vcnt + CNT_ONE;
        end
    end

    assign o_active = (r_hcnt >= HSTART) && (r_hcnt < HEND) &&
                      (r_vcnt >= VSTART) && (r_vcnt < VEND);

endmodule

// File: rtl/video_priority_mixer.sv
// Tile/sprite priority mixer with back colour, blanking and realigned syncs.
// Two-stage pipeline: stage 1 captures the pixel, stage 2 selects the source.
// Define VIDEO_MIXER_LAYER_MASK_EN to add the LMASK layer-disable input.
module video_priority_mixer
    import video_mixer_pkg::*;
#(
    parameter logic [IDX_W-1:0] SPR_TRANS = DEF_SPR_TRANS,
    parameter logic [CNT_W-1:0] HSTART    = DEF_HSTART,
    parameter logic [CNT_W-1:0] HEND      = DEF_HEND,
    parameter logic [CNT_W-1:0] VSTART    = DEF_VSTART,
    parameter logic [CNT_W-1:0] VEND      = DEF_VEND
) (
    input  logic                  CLK_6M,
    input  logic                  nRST,
    video_priority_mixer_if.slave vid
);

    logic             w_active;
    logic [IDX_W-1:0] r_bg;

    logic [IDX_W-1:0] r_s1_dot;
    logic [PRI_W-1:0] r_s1_pr;
    logic [IDX_W-1:0] r_s1_scol;
    logic [PRI_W-1:0] r_s1_spri;
    logic [IDX_W-1:0] r_s1_bg;
    logic             r_s1_active;
    logic             r_s1_hs;
    logic             r_s1_vs;
`ifdef VIDEO_MIXER_LAYER_MASK_EN
    logic [1:0]       r_s1_lmask;
`endif

    logic             w_spr_opaque;
    logic [IDX_W-1:0] w_tile_idx;
    pal_addr_t        w_pal_next;

    pal_addr_t        r_pal;
    logic             r_nblank;
    logic             r_hs_o;
    logic             r_vs_o;

    video_window_counter #(
        .HSTART (HSTART),
        .HEND   (HEND),
        .VSTART (VSTART),
        .VEND   (VEND)
    ) u_win (
        .i_clk     (CLK_6M),
        .i_rst_n   (nRST),
        .i_hsync_n (vid.nHSYNC),
        .i_vsync_n (vid.nVSYNC),
        .o_active  (w_active)
    );

    // CPU back-colour register; stage 1 samples the old value on the write edge.
    always_ff @(posedge CLK_6M) begin
        if (!nRST)
            r_bg <= '0;
        else if (!vid.nBGWE)
            r_bg <= vid.MD;
    end

    // Stage 1: capture the pixel with its window flag, syncs and back colour.
    always_ff @(posedge CLK_6M) begin
        if (!nRST) begin
            r_s1_dot    <= '0;
            r_s1_pr     <= '0;
            r_s1_scol   <= '0;
            r_s1_spri   <= '0;
            r_s1_bg     <= '0;
            r_s1_active <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
`ifdef VIDEO_MIXER_LAYER_MASK_EN
            r_s1_lmask  <= '0;
`endif
        end else begin
            r_s1_dot    <= vid.DOT;
            r_s1_pr     <= vid.PR;
            r_s1_scol   <= vid.SCOL;
            r_s1_spri   <= vid.SPRI;
            r_s1_bg     <= r_bg;
            r_s1_active <= w_active;
            r_s1_hs     <= vid.nHSYNC;
            r_s1_vs     <= vid.nVSYNC;
`ifdef VIDEO_MIXER_LAYER_MASK_EN
            r_s1_lmask  <= vid.LMASK;
`endif
        end
    end

    // Source selection: back colour outside the window, sprite wins ties.
    always_comb begin
        w_spr_opaque = (r_s1_scol != SPR_TRANS) && (r_s1_spri >= r_s1_pr);
        w_tile_idx   = r_s1_dot;
`ifdef VIDEO_MIXER_LAYER_MASK_EN
        if (r_s1_lmask[0])
            w_spr_opaque = 1'b0;
        if (r_s1_lmask[1])
            w_tile_idx = r_s1_bg;
`endif
        if (!r_s1_active)
            w_pal_next = make_pal(1'b0, r_s1_bg);
        else if (w_spr_opaque)
            w_pal_next = make_pal(1'b1, r_s1_scol);
        else
            w_pal_next = make_pal(1'b0, w_tile_idx);
    end

    // Stage 2: registered outputs, all aligned to the same pixel.
    always_ff @(posedge CLK_6M) begin
        if (!nRST) begin
            r_pal    <= '0;
            r_nblank <= 1'b0;
            r_hs_o   <= 1'b1;
            r_vs_o   <= 1'b1;
        end else begin
            r_pal    <= w_pal_next;
            r_nblank <= r_s1_active;
            r_hs_o   <= r_s1_hs;
            r_vs_o   <= r_s1_vs;
        end
    end

    assign vid.PAL_A    = r_pal;
    assign vid.nBLANK   = r_nblank;
    assign vid.nHSYNC_O = r_hs_o;
    assign vid.nVSYNC_O = r_vs_o;

endmodule

// File: tb/tb_video_priority_mixer.sv
// Self-checking bench for video_priority_mixer against a frame-level reference model.
// Build with VIDEO_MIXER_LAYER_MASK_EN defined to cover the layer-mask inputs.
module tb_video_priority_mixer;

  localparam int W = 12;                       // {PAL_A, nBLANK, nHSYNC_O, nVSYNC_O}
  localparam logic [W-1:0] RST_OUT = 12'h003;  // PAL_A=0, nBLANK=0, syncs high

  logic clk;
  logic nrst;

  video_priority_mixer_if vid();

  video_priority_mixer dut (
    .CLK_6M (clk),
    .nRST   (nrst),
    .vid    (vid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: counters as plain integers
  int   m_hcnt;
  int   m_vcnt;
  logic [7:0] m_bg;
  logic m_hs_prev;
  logic m_vs_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model of one clock edge: predicts the output for the pixel sampled now and
  // advances the frame timing by the sync/back-colour rules.
  task automatic model_edge();
    logic act;
    logic opaque;
    logic [7:0] tile;
    logic [8:0] pal;
    logic hfall;
    logic vfall;
    if (!nrst) begin
      m_hcnt = 0;
      m_vcnt = 0;
      m_bg = 8'h00;
      m_hs_prev = 1'b1;
      m_vs_prev = 1'b1;
      exp_q.delete();
      exp_q.push_back(RST_OUT);
      exp_q.push_back(RST_OUT);
    end else begin
      act = (m_hcnt >= 24) && (m_hcnt < 312) && (m_vcnt >= 16) && (m_vcnt < 240);
      opaque = (vid.SCOL != 8'hFF) && (vid.SPRI >= vid.PR);
      tile = vid.DOT;
`ifdef VIDEO_MIXER_LAYER_MASK_EN
      if (vid.LMASK[0]) opaque = 1'b0;
      if (vid.LMASK[1]) tile = m_bg;
`endif
      if (!act)
        pal = {1'b0, m_bg};
      else if (opaque)
        pal = {1'b1, vid.SCOL};
      else
        pal = {1'b0, tile};
      exp_q.push_back({pal, act, vid.nHSYNC, vid.nVSYNC});
      hfall = m_hs_prev && !vid.nHSYNC;
      vfall = m_vs_prev && !vid.nVSYNC;
      if (hfall) m_hcnt = 0;
      else if (m_hcnt < 511) m_hcnt = m_hcnt + 1;
      if (vfall) m_vcnt = 0;
      else if (hfall && m_vcnt < 511) m_vcnt = m_vcnt + 1;
      if (!vid.nBGWE) m_bg = vid.MD;
      m_hs_prev = vid.nHSYNC;
      m_vs_prev = vid.nVSYNC;
    end
  endtask

  // One clock: model the edge, then compare outputs 1 time unit later.
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("pixel", {vid.PAL_A, vid.nBLANK, vid.nHSYNC_O, vid.nVSYNC_O}, e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_pix();
    vid.DOT  = 8'($urandom_range(0, 255));
    vid.PR   = 3'($urandom_range(0, 7));
    vid.SCOL = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    vid.SPRI = 3'($urandom_range(0, 7));
    vid.MD   = 8'($urandom_range(0, 255));
    vid.nBGWE = 1'b1;
`ifdef VIDEO_MIXER_LAYER_MASK_EN
    vid.LMASK = 2'($urandom_range(0, 3));
`endif
  endtask

  task automatic run_line(input int len, input int hlow);
    vid.nHSYNC = 1'b0;
    for (int i = 0; i < hlow; i++) begin rand_pix(); step(); end
    vid.nHSYNC = 1'b1;
    for (int i = hlow; i < len; i++) begin rand_pix(); step(); end
  endtask

  // Hold one pixel for three clocks, then check the palette address it produced.
  task automatic directed(input string tag, input logic [7:0] dot, input logic [2:0] pr,
                          input logic [7:0] scol, input logic [2:0] spri,
                          input logic [1:0] lmask, input logic [8:0] exp_pal);
    vid.DOT = dot; vid.PR = pr; vid.SCOL = scol; vid.SPRI = spri; vid.nBGWE = 1'b1;
`ifdef VIDEO_MIXER_LAYER_MASK_EN
    vid.LMASK = lmask;
`else
    if (lmask != 2'b00) $display("note: lmask ignored in this build");
`endif
    repeat (3) step();
    check(tag, vid.PAL_A, exp_pal);
    check({tag, "_blank"}, vid.nBLANK, 1'b1);
  endtask

  task automatic write_bg(input logic [7:0] v);
    vid.nBGWE = 1'b0;
    vid.MD = v;
    step();
    vid.nBGWE = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    nrst = 1'b0;
    vid.nHSYNC = 1'b1;
    vid.nVSYNC = 1'b1;
    rand_pix();

    // reset with random inputs including syncs
    for (int i = 0; i < 3; i++) begin
      rand_pix();
      vid.nHSYNC = 1'($urandom_range(0, 1));
      vid.nVSYNC = 1'($urandom_range(0, 1));
      step();
      check("rst_pal", vid.PAL_A, 9'h000);
      check("rst_blank", vid.nBLANK, 1'b0);
      check("rst_syncs", {vid.nHSYNC_O, vid.nVSYNC_O}, 2'b11);
    end
    nrst = 1'b1;
    vid.nHSYNC = 1'b1;
    vid.nVSYNC = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_pix(); step(); end

    // back colour outside the window
    write_bg(8'h5A);
    rand_pix(); step();
    rand_pix(); step();
    check("bg_5a", vid.PAL_A, 9'h05A);

    // start of frame, then short lines to cross the top window edge
    vid.nVSYNC = 1'b0;
    rand_pix(); step();
    rand_pix(); step();
    vid.nVSYNC = 1'b1;
    for (int l = 0; l < 20; l++) run_line(40, 2);

    // full-width lines with directed priority cases in the first one
    for (int l = 0; l < 3; l++) begin
      vid.nHSYNC = 1'b0;
      for (int i = 0; i < 4; i++) begin rand_pix(); step(); end
      vid.nHSYNC = 1'b1;
      for (int i = 4; i < 330; i++) begin
        if (l == 0 && i == 100) begin
          directed("pri_eq_spr", 8'h12, 3'd3, 8'h34, 3'd3, 2'b00, 9'h134);
          directed("pri_lo_tile", 8'h12, 3'd3, 8'h34, 3'd2, 2'b00, 9'h012);
          directed("spr_trans", 8'h12, 3'd3, 8'hFF, 3'd7, 2'b00, 9'h012);
`ifdef VIDEO_MIXER_LAYER_MASK_EN
          directed("mask_spr", 8'h12, 3'd3, 8'h34, 3'd3, 2'b01, 9'h012);
          directed("mask_tile", 8'h12, 3'd3, 8'hFF, 3'd3, 2'b10, 9'h05A);
`endif
        end
        rand_pix();
        step();
      end
    end

    // short lines down past the bottom window edge
    while (m_vcnt < 245) run_line(30, 2);

    // simultaneous hsync/vsync falling edges
    vid.nHSYNC = 1'b1; vid.nVSYNC = 1'b1;
    rand_pix(); step();
    vid.nHSYNC = 1'b0; vid.nVSYNC = 1'b0;
    rand_pix(); step();
    check("sim_hcnt", dut.u_win.r_hcnt, 9'd0);
    check("sim_vcnt", dut.u_win.r_vcnt, 9'd0);
    vid.nHSYNC = 1'b1; vid.nVSYNC = 1'b1;
    rand_pix(); step();

    // back-colour write outside the window
    write_bg(8'h3C);
    rand_pix(); step();
    rand_pix(); step();
    check("bg_3c", vid.PAL_A, 9'h03C);

    // hcnt saturation with hsync held high
    for (int i = 0; i < 600; i++) begin rand_pix(); step(); end
    check("hcnt_sat", dut.u_win.r_hcnt, 9'h1FF);
    check("hcnt_model", dut.u_win.r_hcnt, 32'(m_hcnt));
    check("sat_blank", vid.nBLANK, 1'b0);

    // random syncs, back-colour writes and a mid-run reset
    for (int i = 0; i < 400; i++) begin
      rand_pix();
      if ($urandom_range(0, 9) == 0) vid.nHSYNC = ~vid.nHSYNC;
      if ($urandom_range(0, 49) == 0) vid.nVSYNC = ~vid.nVSYNC;
      if ($urandom_range(0, 19) == 0) vid.nBGWE = 1'b0;
      nrst = (i >= 200 && i < 202) ? 1'b0 : 1'b1;
      step();
      if (i == 202) check("midrst_pal", vid.PAL_A, 9'h000);
    end
    nrst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
